// File: rtl/sqrt_iter_unit_if.sv
// rtl/sqrt_iter_unit_if.sv - start/done request and result bundle for the square root engine
interface sqrt_iter_unit_if #(
    parameter int WIDTH = 16
);
    logic               start;
    logic               abort;
    logic [WIDTH-1:0]   x_in;
    logic               ready;
    logic               busy;
    logic               done;
    logic [WIDTH/2-1:0] root;
    logic [WIDTH/2:0]   rem;
    logic               is_square;

    modport master (
        output start, abort, x_in,
        input  ready, busy, done, root, rem, is_square
    );

    modport slave (
        input  start, abort, x_in,
        output ready, busy, done, root, rem, is_square
    );
endinterface

// File: rtl/sqrt_iter_unit.sv
// rtl/sqrt_iter_unit.sv - sequential integer square root (odd-subtract or restoring digit-by-digit)
module sqrt_iter_unit #(
    parameter int WIDTH = 16,
    parameter int MODE  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    sqrt_iter_unit_if.slave   bus
);
    localparam int HW = WIDTH / 2;
    localparam int CW = (HW > 2) ? $clog2(HW) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    // acc_q: remaining operand (odd-subtract) or operand shift register (restoring)
    logic [WIDTH-1:0] acc_q, acc_d;
    // aux_q: next odd number (odd-subtract) or partial remainder (restoring)
    logic [HW:0]     aux_q, aux_d;
    logic [HW-1:0]   r_q, r_d;
    logic [CW-1:0]   cnt_q;
    // first CALC cycle seeds the working registers
    logic            load_q;

    logic            ready_q, busy_q, done_q, sq_q;
    logic [HW-1:0]   root_q;
    logic [HW:0]     rem_q;

    logic            fin;
    logic [HW-1:0]   res_root;
    logic [HW:0]     res_rem;
    logic [HW+2:0]   trial;

    // One iteration of the selected algorithm and its completion test
    always_comb begin
        acc_d    = acc_q;
        aux_d    = aux_q;
        r_d      = r_q;
        fin      = 1'b0;
        res_root = r_q;
        res_rem  = aux_q;
        trial    = '0;
        if (MODE == 0) begin
            if ({{(WIDTH-HW-1){1'b0}}, aux_q} <= acc_q) begin
                acc_d = acc_q - {{(WIDTH-HW-1){1'b0}}, aux_q};
                aux_d = aux_q + (HW+1)'(2);
                r_d   = r_q + HW'(1);
            end else begin
                fin     = 1'b1;
                res_rem = acc_q[HW:0];
            end
        end else begin
            trial = {aux_q, acc_q[WIDTH-1 -: 2]} - {1'b0, r_q, 2'b01};
            if (!trial[HW+2]) begin
                aux_d = trial[HW:0];
                r_d   = {r_q[HW-2:0], 1'b1};
            end else begin
                aux_d = {aux_q[HW-2:0], acc_q[WIDTH-1 -: 2]};
                r_d   = {r_q[HW-2:0], 1'b0};
            end
            acc_d    = {acc_q[WIDTH-3:0], 2'b00};
            fin      = (cnt_q == CW'(HW-1));
            res_root = r_d;
            res_rem  = aux_d;
        end
    end

    // Control FSM, working registers and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            aux_q   <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            load_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sq_q    <= 1'b0;
            root_q  <= '0;
            rem_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_q <= S_CALC;
                        acc_q   <= bus.x_in;
                        load_q  <= 1'b1;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (bus.abort) begin
                        state_q <= S_IDLE;
                        load_q  <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (load_q) begin
                        load_q <= 1'b0;
                        aux_q  <= (MODE == 0) ? (HW+1)'(1) : '0;
                        r_q    <= '0;
                        cnt_q  <= '0;
                    end else begin
                        acc_q <= acc_d;
                        aux_q <= aux_d;
                        r_q   <= r_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (fin) begin
                            state_q <= S_DONE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            root_q  <= res_root;
                            rem_q   <= res_rem;
                            sq_q    <= (res_rem == '0);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.root      = root_q;
    assign bus.rem       = rem_q;
    assign bus.is_square = sq_q;
endmodule

// File: tb/tb_sqrt_iter_unit.sv
// tb/tb_sqrt_iter_unit.sv - scoreboard bench for both sqrt_iter_unit algorithms
module tb_sqrt_iter_unit;
    typedef struct {
        int x;
        int root;
        int rem;
        int sq;
        int acc_edge;
        int lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n_a [2];
    logic       start_a [2];
    logic       abort_a [2];
    logic [15:0] x_a    [2];
    logic       ready_a [2];
    logic       busy_a  [2];
    logic       done_a  [2];
    logic       sq_a    [2];
    logic [7:0] root_a  [2];
    logic [8:0] rem_a   [2];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   edge_cnt = 0;
    int   prev_done [2];
    int   last_root [2];
    int   last_rem  [2];
    exp_t exp0 [$];
    exp_t exp1 [$];

    sqrt_iter_unit_if #(.WIDTH(16)) bus0 ();
    sqrt_iter_unit_if #(.WIDTH(16)) bus1 ();

    assign bus0.start = start_a[0];
    assign bus0.abort = abort_a[0];
    assign bus0.x_in  = x_a[0];
    assign bus1.start = start_a[1];
    assign bus1.abort = abort_a[1];
    assign bus1.x_in  = x_a[1];
    assign ready_a[0] = bus0.ready;
    assign busy_a[0]  = bus0.busy;
    assign done_a[0]  = bus0.done;
    assign sq_a[0]    = bus0.is_square;
    assign root_a[0]  = bus0.root;
    assign rem_a[0]   = bus0.rem;
    assign ready_a[1] = bus1.ready;
    assign busy_a[1]  = bus1.busy;
    assign done_a[1]  = bus1.done;
    assign sq_a[1]    = bus1.is_square;
    assign root_a[1]  = bus1.root;
    assign rem_a[1]   = bus1.rem;

    sqrt_iter_unit #(.WIDTH(16), .MODE(0)) dut0 (.clk(clk), .rst_n(rst_n_a[0]), .bus(bus0));
    sqrt_iter_unit #(.WIDTH(16), .MODE(1)) dut1 (.clk(clk), .rst_n(rst_n_a[1]), .bus(bus1));

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt = edge_cnt + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: largest r with r*r <= x, found by plain counting
    task automatic model(input int x, output int r, output int rm);
        r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        rm = x - r * r;
    endtask

    function automatic int q_size(input int m);
        return (m == 0) ? exp0.size() : exp1.size();
    endfunction

    task automatic pop_exp(input int m, output exp_t e);
        if (m == 0) e = exp0.pop_front();
        else        e = exp1.pop_front();
    endtask

    task automatic monitor_step(input int m);
        exp_t e;
        int   r, rm;
        chk($sformatf("m%0d busy_vs_ready", m), int'(busy_a[m]), int'(!ready_a[m]));
        if (done_a[m]) begin
            chk($sformatf("m%0d done_width", m), prev_done[m], 0);
            if (q_size(m) == 0) begin
                chk($sformatf("m%0d unexpected_done", m), 1, 0);
            end else begin
                pop_exp(m, e);
                r  = int'(root_a[m]);
                rm = int'(rem_a[m]);
                chk($sformatf("m%0d root x=%0d", m, e.x), r, e.root);
                chk($sformatf("m%0d rem x=%0d", m, e.x), rm, e.rem);
                chk($sformatf("m%0d is_square x=%0d", m, e.x), int'(sq_a[m]), e.sq);
                chk($sformatf("m%0d latency x=%0d", m, e.x), edge_cnt - e.acc_edge, e.lat);
                chk($sformatf("m%0d identity x=%0d", m, e.x), r * r + rm, e.x);
                chk($sformatf("m%0d rem_bound x=%0d", m, e.x), int'(rm <= 2 * r), 1);
            end
        end
        prev_done[m] = int'(done_a[m]);
    endtask

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) monitor_step(m);
    end

    task automatic do_start(input int m, input int x, input bit push);
        int   waited = 0;
        int   r, rm;
        exp_t e;
        @(negedge clk);
        while (!ready_a[m] && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!ready_a[m]) begin
            chk($sformatf("m%0d ready_timeout x=%0d", m, x), 0, 1);
            return;
        end
        start_a[m] = 1'b1;
        x_a[m]     = 16'(x);
        if (push) begin
            model(x, r, rm);
            e.x = x; e.root = r; e.rem = rm; e.sq = (rm == 0) ? 1 : 0;
            e.acc_edge = edge_cnt + 1;
            e.lat = (m == 0) ? r + 2 : 9;
            if (m == 0) exp0.push_back(e);
            else        exp1.push_back(e);
            last_root[m] = r;
            last_rem[m]  = rm;
        end
        @(negedge clk);
        start_a[m] = 1'b0;
        x_a[m]     = 16'($urandom);
    endtask

    task automatic wait_idle(input int m);
        int waited = 0;
        while ((q_size(m) != 0 || !ready_a[m]) && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (q_size(m) != 0 || !ready_a[m]) chk($sformatf("m%0d idle_timeout", m), 0, 1);
        @(negedge clk);
    endtask

    task automatic check_reset_state(input int m, input string tag);
        chk($sformatf("m%0d %s root", m, tag), int'(root_a[m]), 0);
        chk($sformatf("m%0d %s rem", m, tag), int'(rem_a[m]), 0);
        chk($sformatf("m%0d %s is_square", m, tag), int'(sq_a[m]), 0);
        chk($sformatf("m%0d %s done", m, tag), int'(done_a[m]), 0);
        chk($sformatf("m%0d %s busy", m, tag), int'(busy_a[m]), 0);
        chk($sformatf("m%0d %s ready", m, tag), int'(ready_a[m]), 1);
    endtask

    task automatic run_mode(input int m);
        int dir [4] = '{0, 49, 50, 65535};
        int x, k, pr_root, pr_rem;
        foreach (dir[i]) do_start(m, dir[i], 1'b1);
        wait_idle(m);

        // start while busy is ignored; start in the done cycle is taken
        do_start(m, 50, 1'b1);
        repeat (3) @(negedge clk);
        chk($sformatf("m%0d busy_at_ignored_start", m), int'(ready_a[m]), 0);
        start_a[m] = 1'b1;
        x_a[m]     = 16'd9;
        @(negedge clk);
        start_a[m] = 1'b0;
        do_start(m, 9, 1'b1);
        wait_idle(m);

        // abort in the third CALC cycle keeps the earlier result
        pr_root = last_root[m];
        pr_rem  = last_rem[m];
        do_start(m, 49, 1'b0);
        repeat (2) @(negedge clk);
        abort_a[m] = 1'b1;
        @(negedge clk);
        abort_a[m] = 1'b0;
        chk($sformatf("m%0d abort ready", m), int'(ready_a[m]), 1);
        chk($sformatf("m%0d abort busy", m), int'(busy_a[m]), 0);
        chk($sformatf("m%0d abort root_hold", m), int'(root_a[m]), pr_root);
        chk($sformatf("m%0d abort rem_hold", m), int'(rem_a[m]), pr_rem);
        repeat (20) @(negedge clk);
        do_start(m, 16, 1'b1);
        wait_idle(m);

        // asynchronous reset in the middle of a calculation
        do_start(m, 200, 1'b0);
        repeat (2) @(negedge clk);
        rst_n_a[m] = 1'b0;
        #1;
        check_reset_state(m, "midreset");
        @(negedge clk);
        rst_n_a[m] = 1'b1;
        do_start(m, 1, 1'b1);
        wait_idle(m);

        for (int i = 0; i < 150; i++) begin
            case (i % 5)
                0: begin k = int'($urandom_range(0, 255)); x = k * k; end
                1: begin k = int'($urandom_range(1, 256)); x = k * k - 1; end
                default: x = int'($urandom_range(0, 65535));
            endcase
            do_start(m, x, 1'b1);
        end
        wait_idle(m);
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            rst_n_a[m] = 1'b0;
            start_a[m] = 1'b0;
            abort_a[m] = 1'b0;
            x_a[m]     = '0;
            prev_done[m] = 0;
            last_root[m] = 0;
            last_rem[m]  = 0;
        end
        repeat (3) @(negedge clk);
        for (int m = 0; m < 2; m++) check_reset_state(m, "reset");
        rst_n_a[0] = 1'b1;
        rst_n_a[1] = 1'b1;
        fork
            run_mode(0);
            run_mode(1);
        join
        chk("m0 leftover_expected", exp0.size(), 0);
        chk("m1 leftover_expected", exp1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
